// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter
//   Round-robin arbiter and transaction sequencer that shares one spi_master
//   between NUM_REQ local requesters. A granted request produces a one-cycle
//   strobe (spi_cs low with spi_wr or spi_rd). The transfer is then timed with
//   a down-counter, because spi_master gives no completion flag. At the end
//   spi_out_data is captured and returned to the owner with a done pulse.
//
// Ports
//   clk, rst      system clock (rising edge), asynchronous active-high reset
//   req           per-requester request level
//   req_rd        per-requester op select: 1 = read, 0 = write
//   req_data      flattened write data, requester i at [i*DATA_W +: DATA_W]
//   gnt           one-hot, one-cycle pulse when a request is accepted
//   done          one-hot, one-cycle pulse when rsp_data is valid for the owner
//   rsp_data      last captured spi_out_data
//   busy          high in every state except IDLE
//   spi_in_data   write data to spi_master
//   spi_wr        write strobe to spi_master
//   spi_rd        read strobe to spi_master
//   spi_cs        chip select to spi_master, active low
//   spi_out_data  read data from spi_master
//
// State     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting; round-robin pick among raised req bits
// S_ISSUE   | one strobe cycle: spi_cs low, spi_wr/spi_rd high, gnt pulse
// S_WAIT    | XFER_CYCLES cycles while spi_master shifts the byte
// S_CAPTURE | sample spi_out_data, advance the round-robin pointer
// S_GAP     | GAP_CYCLES idle cycles with spi_cs high before the next pick
//
// All outputs are registered. Their next values are derived from the state
// being entered, so each output lines up with the state it belongs to.

module spi_master_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int XFER_CYCLES = 18,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_rd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy,
    output logic [DATA_W-1:0]         spi_in_data,
    output logic                      spi_wr,
    output logic                      spi_rd,
    output logic                      spi_cs,
    input  logic [DATA_W-1:0]         spi_out_data
);

    localparam int IW      = $clog2(NUM_REQ);
    localparam int CNT_MAX = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [IW-1:0]      LAST_IDX  = IW'(NUM_REQ - 1);
    localparam logic [IW:0]        NUM_WIDE  = (IW+1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);
    localparam logic [CW-1:0]      XFER_LOAD = CW'(XFER_CYCLES);
    localparam logic [CW-1:0]      GAP_LOAD  = CW'(GAP_CYCLES);
    localparam logic [CW-1:0]      CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       win_q, win_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   spi_in_data_q, spi_in_data_d;
    logic                spi_wr_q, spi_wr_d;
    logic                spi_rd_q, spi_rd_d;
    logic                spi_cs_q, spi_cs_d;

    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic [IW:0]         cand;
    logic [IW-1:0]       sel_idx;
    logic                sel_vld;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Round-robin search: first raised req at or above ptr, wrapping. The
    // candidate index is kept one bit wider so ptr + k never overflows before
    // the wrap subtraction.
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= NUM_WIDE) begin
                cand = cand - NUM_WIDE;
            end
            if (!sel_vld && req[cand[IW-1:0]]) begin
                sel_vld = 1'b1;
                sel_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        win_d         = win_q;
        cnt_d         = cnt_q;
        gnt_d         = '0;
        done_d        = '0;
        rsp_data_d    = rsp_data_q;
        spi_in_data_d = spi_in_data_q;
        spi_wr_d      = 1'b0;
        spi_rd_d      = 1'b0;
        spi_cs_d      = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (sel_vld) begin
                    state_d       = S_ISSUE;
                    win_d         = sel_idx;
                    gnt_d         = ONE_HOT0 << sel_idx;
                    spi_in_data_d = data_arr[sel_idx];
                    spi_cs_d      = 1'b0;
                    spi_wr_d      = ~req_rd[sel_idx];
                    spi_rd_d      = req_rd[sel_idx];
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = XFER_LOAD;
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rsp_data_d = spi_out_data;
                done_d     = ONE_HOT0 << win_q;
                ptr_d      = (win_q == LAST_IDX) ? '0 : win_q + IW'(1);
                if (GAP_CYCLES == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            S_GAP: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            win_q         <= '0;
            cnt_q         <= '0;
            gnt_q         <= '0;
            done_q        <= '0;
            rsp_data_q    <= '0;
            busy_q        <= 1'b0;
            spi_in_data_q <= '0;
            spi_wr_q      <= 1'b0;
            spi_rd_q      <= 1'b0;
            spi_cs_q      <= 1'b1;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            win_q         <= win_d;
            cnt_q         <= cnt_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            rsp_data_q    <= rsp_data_d;
            busy_q        <= busy_d;
            spi_in_data_q <= spi_in_data_d;
            spi_wr_q      <= spi_wr_d;
            spi_rd_q      <= spi_rd_d;
            spi_cs_q      <= spi_cs_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = busy_q;
    assign spi_in_data = spi_in_data_q;
    assign spi_wr      = spi_wr_q;
    assign spi_rd      = spi_rd_q;
    assign spi_cs      = spi_cs_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level round-robin model. A second instance
// is built with GAP_CYCLES = 0 for the back-to-back spacing scenario.

module tb_spi_master_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int XFER    = 18;
    localparam int GAP     = 2;
    localparam int TW      = NUM_REQ * DATA_W;
    localparam int TXN     = XFER + 3 + GAP;   // issue-to-issue spacing
    localparam int DONE_AT = XFER + 3;         // done cycle when req sampled at edge 0

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0] req, req_rd, gnt, done;
    logic [TW-1:0]      req_data;
    logic [DATA_W-1:0]  rsp_data, spi_in_data, spi_out_data;
    logic               busy, spi_wr, spi_rd, spi_cs;

    logic [NUM_REQ-1:0] z_req, z_req_rd, z_gnt, z_done;
    logic [TW-1:0]      z_req_data;
    logic [DATA_W-1:0]  z_rsp_data, z_spi_in_data, z_spi_out_data;
    logic               z_busy, z_spi_wr, z_spi_rd, z_spi_cs;

    int checks   = 0;
    int failures = 0;

    spi_master_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .XFER_CYCLES(XFER), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .req(req), .req_rd(req_rd), .req_data(req_data),
        .gnt(gnt), .done(done), .rsp_data(rsp_data), .busy(busy),
        .spi_in_data(spi_in_data), .spi_wr(spi_wr), .spi_rd(spi_rd), .spi_cs(spi_cs),
        .spi_out_data(spi_out_data)
    );

    spi_master_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .XFER_CYCLES(XFER), .GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .rst(rst), .req(z_req), .req_rd(z_req_rd), .req_data(z_req_data),
        .gnt(z_gnt), .done(z_done), .rsp_data(z_rsp_data), .busy(z_busy),
        .spi_in_data(z_spi_in_data), .spi_wr(z_spi_wr), .spi_rd(z_spi_rd), .spi_cs(z_spi_cs),
        .spi_out_data(z_spi_out_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [DATA_W-1:0] v);
        logic [TW-1:0] mask;
        mask     = TW'({DATA_W{1'b1}}) << (i * DATA_W);
        req_data = (req_data & ~mask) | (TW'(v) << (i * DATA_W));
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = (p + k) % NUM_REQ;
            if (((r >> j) & NUM_REQ'(1)) != '0) return j;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v == (NUM_REQ'(1) << k)) return k;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req = '0; req_rd = '0; req_data = '0; spi_out_data = '0;
        z_req = '0; z_req_rd = '0; z_req_data = '0; z_spi_out_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (gnt !== '0 || done !== '0 || rsp_data !== '0 || busy !== 1'b0 ||
            spi_in_data !== '0 || spi_wr !== 1'b0 || spi_rd !== 1'b0 || spi_cs !== 1'b1) begin
            failures++;
            $display("FAIL reset_values: gnt=%b done=%b rsp=%h busy=%b in=%h wr=%b rd=%b cs=%b, required 0000 0000 00 0 00 0 0 1",
                     gnt, done, rsp_data, busy, spi_in_data, spi_wr, spi_rd, spi_cs);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || spi_cs !== 1'b1 || gnt !== '0) begin
            failures++;
            $display("FAIL reset_idle_hold: busy=%b cs=%b gnt=%b, required 0 1 0000", busy, spi_cs, gnt);
        end
    endtask

    task automatic test_single_write();
        int n_wr = 0, n_done = 0, done_at = -1;
        bit rd_seen = 0;
        logic [NUM_REQ-1:0] done_val = '0;
        req_rd[0] = 1'b0;
        set_data(0, 8'hAA);
        req[0] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if (gnt !== 4'b0001 || spi_wr !== 1'b1 || spi_cs !== 1'b0 || spi_in_data !== 8'hAA || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL write_issue: gnt=%b wr=%b cs=%b in=%h busy=%b, required 0001 1 0 aa 1",
                             gnt, spi_wr, spi_cs, spi_in_data, busy);
                end
            end
            if (spi_wr === 1'b1) n_wr++;
            if (spi_rd !== 1'b0) rd_seen = 1;
            if (done !== '0) begin
                n_done++;
                if (done_at < 0) begin done_at = c; done_val = done; end
            end
            if (c == DONE_AT) req[0] = 1'b0;
        end
        checks++;
        if (n_wr != 1 || rd_seen) begin
            failures++;
            $display("FAIL write_strobes: wr_cycles=%0d rd_seen=%0d, required 1 0", n_wr, rd_seen);
        end
        checks++;
        if (done_at != DONE_AT || done_val !== 4'b0001 || n_done != 1) begin
            failures++;
            $display("FAIL write_done: cycle=%0d val=%b count=%0d, required %0d 0001 1", done_at, done_val, n_done, DONE_AT);
        end
    endtask

    task automatic test_single_read();
        int done_at = -1;
        logic [NUM_REQ-1:0] done_val = '0;
        logic [DATA_W-1:0]  rsp_at_done = '0;
        req_rd[2] = 1'b1;
        set_data(2, 8'h00);
        req[2] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if (gnt !== 4'b0100 || spi_rd !== 1'b1 || spi_wr !== 1'b0 || spi_cs !== 1'b0) begin
                    failures++;
                    $display("FAIL read_issue: gnt=%b rd=%b wr=%b cs=%b, required 0100 1 0 0", gnt, spi_rd, spi_wr, spi_cs);
                end
                spi_out_data = 8'h5C;
            end
            if (done !== '0 && done_at < 0) begin
                done_at = c; done_val = done; rsp_at_done = rsp_data;
            end
            if (c == DONE_AT) req[2] = 1'b0;
        end
        checks++;
        if (done_at != DONE_AT || done_val !== 4'b0100 || rsp_at_done !== 8'h5C) begin
            failures++;
            $display("FAIL read_done: cycle=%0d val=%b rsp=%h, required %0d 0100 5c", done_at, done_val, rsp_at_done, DONE_AT);
        end
    endtask

    task automatic test_contention();
        logic [DATA_W-1:0] exp_d [NUM_REQ];
        int g_idx [5];
        int g_cyc [5];
        logic [DATA_W-1:0] g_dat [5];
        int n = 0;
        exp_d[0] = 8'h91; exp_d[1] = 8'hF0; exp_d[2] = 8'h12; exp_d[3] = 8'h34;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_data(i, exp_d[i]);
        req = 4'b1111;
        for (int c = 1; c <= 5 * TXN + 10 && n < 5; c++) begin
            tick();
            checks++;
            if ((gnt !== '0 && done !== '0) || !$onehot0(gnt) || !$onehot0(done)) begin
                failures++;
                $display("FAIL contention_onehot: gnt=%b done=%b, required one-hot and disjoint in time", gnt, done);
            end
            if (gnt !== '0) begin
                g_idx[n] = idx_of(gnt); g_cyc[n] = c; g_dat[n] = spi_in_data; n++;
            end
        end
        checks++;
        if (n != 5) begin
            failures++;
            $display("FAIL contention_count: grants=%0d, required 5", n);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (g_idx[k] != k % NUM_REQ || g_dat[k] !== exp_d[k % NUM_REQ]) begin
                failures++;
                $display("FAIL contention_order[%0d]: idx=%0d data=%h, required %0d %h",
                         k, g_idx[k], g_dat[k], k % NUM_REQ, exp_d[k % NUM_REQ]);
            end
            if (k > 0) begin
                checks++;
                if (g_cyc[k] - g_cyc[k-1] != TXN) begin
                    failures++;
                    $display("FAIL contention_spacing[%0d]: %0d cycles, required %0d", k, g_cyc[k] - g_cyc[k-1], TXN);
                end
            end
        end
        req = '0;
    endtask

    task automatic test_fairness();
        int g_idx [3];
        int n = 0;
        int first_c = -1;
        do_reset();
        req = 4'b0010;
        for (int c = 1; c <= 4 * TXN && n < 3; c++) begin
            tick();
            if (gnt !== '0) begin
                g_idx[n] = idx_of(gnt);
                if (n == 0) first_c = c;
                if (gnt === 4'b1000) req[3] = 1'b0;
                n++;
            end
            if (first_c > 0 && c == first_c + 5) req[3] = 1'b1;
        end
        checks++;
        if (n != 3 || g_idx[0] != 1 || g_idx[1] != 3 || g_idx[2] != 1) begin
            failures++;
            $display("FAIL fairness_order: n=%0d order=%0d,%0d,%0d, required 3 grants 1,3,1",
                     n, g_idx[0], g_idx[1], g_idx[2]);
        end
        req = '0;
    endtask

    task automatic test_reset_mid_wait();
        int first_g = -1;
        int n_done2 = 0;
        do_reset();
        req[2] = 1'b1;
        tick();
        req[2] = 1'b0;
        spi_out_data = 8'hE7;
        for (int c = 2; c <= TXN + 2; c++) tick();
        checks++;
        if (rsp_data !== 8'hE7) begin
            failures++;
            $display("FAIL abort_setup_rsp: rsp=%h, required e7", rsp_data);
        end
        req[2] = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0100) begin
            failures++;
            $display("FAIL abort_setup_gnt: gnt=%b, required 0100", gnt);
        end
        req[2] = 1'b0;
        for (int c = 2; c <= 10; c++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (spi_cs !== 1'b1 || busy !== 1'b0 || gnt !== '0 || done !== '0 || rsp_data !== '0 ||
            spi_wr !== 1'b0 || spi_rd !== 1'b0) begin
            failures++;
            $display("FAIL abort_immediate: cs=%b busy=%b gnt=%b done=%b rsp=%h wr=%b rd=%b, required 1 0 0000 0000 00 0 0",
                     spi_cs, busy, gnt, done, rsp_data, spi_wr, spi_rd);
        end
        tick();
        rst = 1'b0;
        req = 4'b1010;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (gnt !== '0 && first_g < 0) begin
                first_g = idx_of(gnt);
                req = req & ~gnt;
            end
            if (done[2] === 1'b1) n_done2++;
        end
        checks++;
        if (first_g != 1 || n_done2 != 0) begin
            failures++;
            $display("FAIL abort_restart: first_gnt=%0d stale_done=%0d, required 1 0", first_g, n_done2);
        end
        req = '0;
    endtask

    task automatic test_random();
        int m_ptr = 0, next_ok = 1, gnt_cyc = -1, done_due = -1, done_idx = 0, w;
        logic [DATA_W-1:0]  done_rsp = '0, exp_in;
        logic [NUM_REQ-1:0] r_prev, rd_prev, exp_gnt, exp_done, tmp;
        logic [TW-1:0]      d_prev;
        logic exp_cs, exp_wr, exp_rd, exp_busy;
        int wait_c [NUM_REQ];
        bit waiting [NUM_REQ];
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            wait_c[i] = $urandom_range(0, 6);
            waiting[i] = 0;
        end
        for (int c = 1; c <= 1500; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!waiting[i]) begin
                    if (wait_c[i] == 0) begin
                        req = req | (NUM_REQ'(1) << i);
                        tmp = NUM_REQ'(1) << i;
                        req_rd = ($urandom_range(0, 1) == 1) ? (req_rd | tmp) : (req_rd & ~tmp);
                        set_data(i, DATA_W'($urandom));
                        waiting[i] = 1;
                    end else begin
                        wait_c[i]--;
                    end
                end
            end
            r_prev = req; rd_prev = req_rd; d_prev = req_data;
            tick();
            exp_gnt = '0; exp_cs = 1'b1; exp_wr = 1'b0; exp_rd = 1'b0;
            if (c >= next_ok && r_prev != '0) begin
                w = rr_pick(r_prev, m_ptr);
                tmp = rd_prev >> w;
                exp_gnt = NUM_REQ'(1) << w;
                exp_cs = 1'b0; exp_rd = tmp[0]; exp_wr = ~tmp[0];
                exp_in = DATA_W'(d_prev >> (w * DATA_W));
                m_ptr = (w + 1) % NUM_REQ;
                gnt_cyc = c; next_ok = c + TXN; done_due = c + XFER + 2; done_idx = w;
                checks++;
                if (spi_in_data !== exp_in) begin
                    failures++;
                    $display("FAIL rand_in_data c=%0d: got %h, required %h", c, spi_in_data, exp_in);
                end
                done_rsp = DATA_W'($urandom);
                spi_out_data = done_rsp;
                if ($urandom_range(0, 1) == 1) req = req & ~exp_gnt;
            end
            exp_done = (c == done_due) ? (NUM_REQ'(1) << done_idx) : '0;
            exp_busy = (gnt_cyc >= 0) && (c >= gnt_cyc) && (c < next_ok - 1);
            checks++;
            if (gnt !== exp_gnt || done !== exp_done || spi_cs !== exp_cs || spi_wr !== exp_wr ||
                spi_rd !== exp_rd || busy !== exp_busy) begin
                failures++;
                $display("FAIL rand_cycle c=%0d: gnt=%b done=%b cs=%b wr=%b rd=%b busy=%b, required %b %b %b %b %b %b",
                         c, gnt, done, spi_cs, spi_wr, spi_rd, busy,
                         exp_gnt, exp_done, exp_cs, exp_wr, exp_rd, exp_busy);
            end
            if (c == done_due) begin
                checks++;
                if (rsp_data !== done_rsp) begin
                    failures++;
                    $display("FAIL rand_rsp c=%0d: got %h, required %h", c, rsp_data, done_rsp);
                end
                waiting[done_idx] = 0;
                wait_c[done_idx] = $urandom_range(0, 6);
                req = req & ~(NUM_REQ'(1) << done_idx);
            end
        end
        req = '0;
    endtask

    task automatic test_back_to_back_gap0();
        int n = 0, last = -1, high_run = 0, overlap = 0;
        do_reset();
        z_req_rd[0] = 1'b0;
        z_req_data[DATA_W-1:0] = 8'h3C;
        z_req[0] = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (z_gnt !== '0 && z_done !== '0) overlap++;
            if (z_spi_cs === 1'b0) begin
                if (last >= 0) begin
                    checks++;
                    if (c - last != XFER + 3 || high_run != XFER + 2) begin
                        failures++;
                        $display("FAIL gap0_spacing: %0d cycles apart, cs high %0d, required %0d and %0d",
                                 c - last, high_run, XFER + 3, XFER + 2);
                    end
                end
                last = c; high_run = 0; n++;
            end else begin
                high_run++;
            end
        end
        checks++;
        if (n != 4 || overlap != 0) begin
            failures++;
            $display("FAIL gap0_count: strobes=%0d overlap=%0d, required 4 0", n, overlap);
        end
        z_req = '0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_fairness();
        test_reset_mid_wait();
        test_random();
        test_back_to_back_gap0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Round-robin arbiter and transaction sequencer that shares one spi_master instance between NUM_REQ requesters.
- Accepts byte write/read requests, drives the spi_master strobe interface (in_data, wr, rd, cs), and times each transfer with a counter because spi_master has no done flag.
- Captures out_data at transfer end and returns it to the owning requester with a one-cycle done pulse.
- Sits between the local requesters and spi_master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, transfer width; matches spi_master byte width.
- XFER_CYCLES, 18, clk cycles from the strobe cycle's end until spi_master out_data is valid.
- GAP_CYCLES, 2, idle cycles with spi_cs high between transactions (0 allowed).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level.
- req_rd  input  NUM_REQ  per-requester op select: 1=read (spi_rd), 0=write (spi_wr).
- req_data  input  NUM_REQ*DATA_W  flattened write data; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot, one-cycle pulse when a request is accepted.
- done  output  NUM_REQ  one-hot, one-cycle pulse when rsp_data is valid for that requester.
- rsp_data  output  DATA_W  captured spi_out_data; holds until the next capture.
- busy  output  1  high in every state except IDLE.
- spi_in_data  output  DATA_W  to spi_master in_data.
- spi_wr  output  1  to spi_master wr.
- spi_rd  output  1  to spi_master rd.
- spi_cs  output  1  to spi_master cs; active-low.
- spi_out_data  input  DATA_W  from spi_master out_data.

Behaviour:
- Reset values (async, immediate on rst): state IDLE; gnt=0; done=0; rsp_data=0; busy=0; spi_in_data=0; spi_wr=0; spi_rd=0; spi_cs=1; RR pointer=0; counters=0. All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, GAP.
- IDLE: if any req bit is set, select the winner by round-robin search starting at index ptr, ascending and wrapping. Latch winner index, req_rd[w] and req_data slice. Go to ISSUE. If no req bit is set, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - spi_cs=0; spi_wr=~op_rd; spi_rd=op_rd; spi_in_data=latched data.
  - gnt[w]=1 this cycle.
  - Load counter with XFER_CYCLES, then go to WAIT.
- WAIT: spi_cs=1, spi_wr=0, spi_rd=0. spi_in_data holds its value. Counter decrements each cycle; when it reaches 1, go to CAPTURE (WAIT lasts exactly XFER_CYCLES cycles).
- CAPTURE (1 cycle): rsp_data<=spi_out_data, registered at the end of this cycle. done[w] pulses in the following cycle, aligned with valid rsp_data. ptr<=(w+1) mod NUM_REQ. Go to GAP, or to IDLE if GAP_CYCLES=0.
- GAP: hold idle for GAP_CYCLES cycles, then go to IDLE. done pulse occurs in the first GAP/IDLE cycle.
- Latency: with req rising so it is sampled in IDLE at edge 0, ISSUE is cycle 1, WAIT is cycles 2..XFER_CYCLES+1, CAPTURE is cycle XFER_CYCLES+2, and done is at cycle XFER_CYCLES+3 (21 with defaults).
- Handshake:
  - req is a level and must stay high with stable req_rd/req_data until gnt; data is latched in IDLE.
  - Requester deasserts req upon done. req still high after done is a new request.
  - req dropped after gnt does not abort the transfer.
- Fairness: a requester re-requesting immediately is served only after all other pending requesters (ptr advances past it).
- Simultaneous requests: lowest index at or above ptr wins; with ptr=0 and req=4'b1111, the order is 0,1,2,3,0,...
- req changes during busy: ignored until IDLE.
- Reset mid-operation: transaction discarded, no done, spi_cs returns high at once; no partial state survives.
- gnt and done are never asserted in the same cycle, and at most one bit of each is set.

Test Plan:
- Single write: req[0]=1, req_rd[0]=0, data0=8'hAA. Required: one cycle with spi_wr=1, spi_cs=0, spi_in_data=8'hAA and gnt[0]=1; done[0] at cycle 21; spi_rd never high.
- Single read: req[2]=1, req_rd[2]=1, bench drives spi_out_data=8'h5C during WAIT. Required: spi_rd pulse with gnt[2]; done[2] with rsp_data=8'h5C.
- Contention: req=4'b1111 held with data 8'h91, 8'hF0, 8'h12, 8'h34. Required: gnt order 0,1,2,3,0 with matching spi_in_data; transactions spaced XFER_CYCLES+3+GAP_CYCLES cycles (23 with defaults).
- Fairness: req[1] held continuously, req[3] raised while requester 1 is busy. Required: next gnt goes to 3, then 1.
- Reset mid-WAIT: rst pulsed during cycle 10 of a transfer. Required: spi_cs=1, busy=0, gnt=0, done=0, rsp_data=0 immediately; no done pulse; next request is served from ptr=0.
- GAP_CYCLES=0 build with back-to-back req[0]. Required: ISSUE cycles exactly 21 cycles apart; spi_cs high for at least 20 cycles between strobes.
